wb_sram_slave: RTL

- Wishbone B4 pipelined slave that terminates the bus driven by the core's Wishbone master bridge, directly or through the interconnect, onto a single-port synchronous SRAM with 1-cycle read latency.
- Serves single-beat uncached accesses and 4-beat incrementing cache-line bursts (CTI INCR/EOB).
- Allows one transfer in flight and back-pressures with stall so a master that holds stb/adr until ack is never double-accepted.

---
 rtl/wb_sram_slave.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wb_sram_slave.sv
// Wishbone B4 pipelined slave in front of a single-port synchronous SRAM
// (1-cycle read latency). One transfer in flight; stall is raised in the
// response cycle so a master that holds stb/adr until ack is accepted once.
// Serves classic single beats and INCR/EOB cache-line bursts.
// Optional build macro: WB_SRAM_RANGE_ERR_EN -- out-of-window addresses
// return err instead of wrapping onto the SRAM.

package wb_sram_pkg;
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        stb;
        logic        cyc;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } wb_master_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        ack;
        logic        stall;
        logic        err;
        logic        rty;
    } wb_slave_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
endpackage

module wb_sram_slave
    import wb_sram_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          BURST_MAX = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  wb_master_t                   wb_m_i,
    output wb_slave_t                    wb_s_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [31:0]                  mem_wdata_o,
    output logic [3:0]                   mem_be_o,
    input  logic [31:0]                  mem_rdata_i,
    output logic                         busy_o
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_RESP, S_BURST, S_ERR} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          we_q, we_d;
    logic [2:0]    cti_q, cti_d;

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          stall;
    logic          accept;
    logic          ack;
    logic          err;

    // Word index relative to the window base; upper bits drop so it wraps.
    assign off = wb_m_i.adr - BASE_ADDR;
    assign idx = off[AW+1:2];

`ifdef WB_SRAM_RANGE_ERR_EN
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;
    assign in_range = (wb_m_i.adr >= BASE_ADDR) && ({1'b0, off} < SPAN);
`else
    assign in_range = 1'b1;
`endif

    // Stalled while a response (ack or err) is being returned. Accept is
    // gated by reset so the SRAM strobe clears as soon as reset asserts.
    assign stall  = (state_q == S_RESP) || (state_q == S_ERR);
    assign accept = rst_ni & wb_m_i.cyc & wb_m_i.stb & ~stall;
    assign ack    = (state_q == S_RESP) & wb_m_i.cyc;
    assign err    = (state_q == S_ERR) & wb_m_i.cyc;
    assign busy_o = (state_q != S_IDLE);

    // SRAM strobe in the accept cycle; a write with no byte lanes is acked
    // without touching the array, an out-of-window access never reaches it.
    always_comb begin
        mem_req_o   = accept & in_range & ~(wb_m_i.we & (wb_m_i.sel == 4'b0000));
        mem_we_o    = mem_req_o & wb_m_i.we;
        mem_addr_o  = accept ? idx : '0;
        mem_wdata_o = accept ? wb_m_i.dat : '0;
        mem_be_o    = accept ? wb_m_i.sel : '0;
    end

    // Slave response: read data is only presented in a read ack cycle.
    always_comb begin
        wb_s_o       = '0;
        wb_s_o.ack   = ack;
        wb_s_o.err   = err;
        wb_s_o.stall = stall;
        wb_s_o.dat   = (ack & ~we_q) ? mem_rdata_i : 32'h0;
    end

    // Next-state: accept -> response cycle -> idle or back to burst.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        we_d    = we_q;
        cti_d   = cti_q;
        case (state_q)
            S_IDLE, S_BURST: begin
                if (state_q == S_BURST && !wb_m_i.cyc) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end else if (accept) begin
                    we_d    = wb_m_i.we;
                    cti_d   = wb_m_i.cti;
                    state_d = in_range ? S_RESP : S_ERR;
                end
            end
            S_RESP: begin
                if (wb_m_i.cyc && cti_q == CTI_INCR && (int'(beat_q) + 1) < BURST_MAX) begin
                    state_d = S_BURST;
                    beat_d  = beat_q + BW'(1);
                end else begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State and latched request attributes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            we_q    <= 1'b0;
            cti_q   <= CTI_CLASSIC;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
            cti_q   <= cti_d;
        end
    end

    // Address byte-offset bits and bte carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = ^{off[31:AW+2], off[1:0], wb_m_i.bte};

endmodule
